// File: rtl/i2c_scl_timing_gen.sv
// I2C SCL generator: 4-phase bit timebase from ref_clk, open-drain SCL with stretch detect and timeout.
// All outputs registered (1 cycle after the deciding edge); no backpressure, enable is sampled only at bit boundaries.
module i2c_scl_timing_gen #(
    parameter int CNT_W           = 16,
    parameter int DEFAULT_QUARTER = 125,
    parameter int MIN_QUARTER     = 2,
    parameter int STRETCH_W       = 20,
    parameter int STRETCH_MAX     = 500000
) (
    input  logic             i_ref_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_div_load,
    input  logic [CNT_W-1:0] i_div_value,
    input  logic             i_scl_in,
    output logic             o_scl_oe,
    output logic [1:0]       o_phase,
    output logic             o_busy,
    output logic             o_fall_tick,
    output logic             o_data_tick,
    output logic             o_rise_tick,
    output logic             o_sample_tick,
    output logic             o_stretching,
    output logic             o_stretch_timeout
);

    localparam logic [CNT_W-1:0]     DEF_Q      = CNT_W'(DEFAULT_QUARTER);
    localparam logic [CNT_W-1:0]     MIN_Q      = CNT_W'(MIN_QUARTER);
    localparam logic [STRETCH_W-1:0] HOLD_LAST  = STRETCH_W'(STRETCH_MAX - 1);
    localparam bit                   TIMEOUT_EN = (STRETCH_MAX != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW_A,
        S_LOW_B,
        S_HIGH_A,
        S_HIGH_B
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [STRETCH_W-1:0] r_hcnt;
    logic [CNT_W-1:0]     r_active_q;
    logic [CNT_W-1:0]     r_shadow_q;
    logic [1:0]           r_sync;

    logic [CNT_W-1:0]     w_clamped;
    logic                 w_last;
    logic                 w_scl_sync;
    logic [STRETCH_W-1:0] w_hcnt_inc;

    assign w_clamped  = (i_div_value < MIN_Q) ? MIN_Q : i_div_value;
    assign w_last     = (r_cnt == r_active_q - CNT_W'(1));
    assign w_scl_sync = r_sync[1];
    assign w_hcnt_inc = (r_hcnt == '1) ? r_hcnt : r_hcnt + STRETCH_W'(1);

    always_ff @(posedge i_ref_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], i_scl_in};
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shadow_q <= DEF_Q;
        end else if (i_div_load) begin
            r_shadow_q <= w_clamped;
        end
    end

    always_ff @(posedge i_ref_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state           <= S_IDLE;
            r_cnt             <= '0;
            r_hcnt            <= '0;
            r_active_q        <= DEF_Q;
            o_scl_oe          <= 1'b0;
            o_phase           <= 2'd0;
            o_busy            <= 1'b0;
            o_fall_tick       <= 1'b0;
            o_data_tick       <= 1'b0;
            o_rise_tick       <= 1'b0;
            o_sample_tick     <= 1'b0;
            o_stretching      <= 1'b0;
            o_stretch_timeout <= 1'b0;
        end else begin
            o_fall_tick       <= 1'b0;
            o_data_tick       <= 1'b0;
            o_rise_tick       <= 1'b0;
            o_sample_tick     <= 1'b0;
            o_stretching      <= 1'b0;
            o_stretch_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_enable) begin
                        // A load coinciding with bit start only takes effect on the next bit.
                        r_state     <= S_LOW_A;
                        r_cnt       <= '0;
                        r_active_q  <= r_shadow_q;
                        o_scl_oe    <= 1'b1;
                        o_busy      <= 1'b1;
                        o_phase     <= 2'd0;
                        o_fall_tick <= 1'b1;
                    end else begin
                        r_active_q <= i_div_load ? w_clamped : r_shadow_q;
                    end
                end
                S_LOW_A: begin
                    if (w_last) begin
                        r_state     <= S_LOW_B;
                        r_cnt       <= '0;
                        o_phase     <= 2'd1;
                        o_data_tick <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_LOW_B: begin
                    if (w_last) begin
                        r_state     <= S_HIGH_A;
                        r_cnt       <= '0;
                        r_hcnt      <= '0;
                        o_scl_oe    <= 1'b0;
                        o_phase     <= 2'd2;
                        o_rise_tick <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_HIGH_A: begin
                    // r_sync[0] is next cycle's scl_sync, so stretching lines up with the hold cycle itself.
                    if (!w_scl_sync) begin
                        if (TIMEOUT_EN && (r_hcnt == HOLD_LAST)) begin
                            r_state           <= S_IDLE;
                            r_cnt             <= '0;
                            r_hcnt            <= '0;
                            o_busy            <= 1'b0;
                            o_phase           <= 2'd0;
                            o_stretch_timeout <= 1'b1;
                        end else begin
                            r_cnt        <= '0;
                            r_hcnt       <= w_hcnt_inc;
                            o_stretching <= !r_sync[0] && (w_hcnt_inc >= STRETCH_W'(2));
                        end
                    end else if (w_last) begin
                        r_state       <= S_HIGH_B;
                        r_cnt         <= '0;
                        r_hcnt        <= '0;
                        o_phase       <= 2'd3;
                        o_sample_tick <= 1'b1;
                    end else begin
                        r_cnt        <= r_cnt + CNT_W'(1);
                        o_stretching <= !r_sync[0] && (r_hcnt >= STRETCH_W'(2));
                    end
                end
                S_HIGH_B: begin
                    if (w_last) begin
                        r_cnt   <= '0;
                        o_phase <= 2'd0;
                        if (i_enable) begin
                            r_state     <= S_LOW_A;
                            r_active_q  <= r_shadow_q;
                            o_scl_oe    <= 1'b1;
                            o_fall_tick <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                            o_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_scl_timing_gen.sv
// Bench for i2c_scl_timing_gen: per-cycle comparison against a phase/duration model plus directed timing checks.
module tb_i2c_scl_timing_gen;

    localparam int SMAX = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        dl = 1'b0;
    logic [15:0] dv = '0;
    logic        hold_low = 1'b0;
    logic        scl_in;
    logic        scl_oe, busy, ft, dt, rt, st, str, sto;
    logic [1:0]  phase;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave side of the open-drain bus: low if either the master or the "slave" pulls it.
    assign scl_in = ~scl_oe & ~hold_low;

    i2c_scl_timing_gen #(.STRETCH_MAX(SMAX)) dut (
        .i_ref_clk(clk), .i_reset(rst), .i_enable(en), .i_div_load(dl), .i_div_value(dv),
        .i_scl_in(scl_in), .o_scl_oe(scl_oe), .o_phase(phase), .o_busy(busy),
        .o_fall_tick(ft), .o_data_tick(dt), .o_rise_tick(rt), .o_sample_tick(st),
        .o_stretching(str), .o_stretch_timeout(sto)
    );

    function automatic logic [9:0] dut_vec();
        return {scl_oe, phase, busy, ft, dt, rt, st, str, sto};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: phase (-1 = idle), cycles counted in phase, hold cycles, divisor registers.
    int m_ph, m_q, m_shadow, m_cnt, m_holds;
    bit m_s1, m_s2, m_str, m_to;
    bit m_tick [4];

    task automatic model_reset();
        m_ph = -1; m_q = 125; m_shadow = 125; m_cnt = 0; m_holds = 0;
        m_s1 = 1; m_s2 = 1; m_str = 0; m_to = 0;
        for (int i = 0; i < 4; i++) m_tick[i] = 0;
    endtask

    task automatic enter(input int p);
        m_ph = p; m_cnt = 0; m_holds = 0; m_tick[p] = 1;
    endtask

    task automatic model_step(input bit e, input bit l, input int v, input bit scl);
        int nsh;
        nsh = l ? ((v < 2) ? 2 : v) : m_shadow;
        for (int i = 0; i < 4; i++) m_tick[i] = 0;
        m_to = 0;
        if (m_ph == -1) begin
            if (e) begin m_q = m_shadow; enter(0); end
            else m_q = nsh;
        end else if (m_ph == 2) begin
            if (!m_s2) begin
                m_cnt = 0; m_holds++;
                if (SMAX != 0 && m_holds == SMAX) begin m_ph = -1; m_to = 1; end
            end else begin
                m_cnt++;
                if (m_cnt == m_q) enter(3);
            end
        end else begin
            m_cnt++;
            if (m_cnt == m_q) begin
                if (m_ph == 3) begin
                    if (e) begin m_q = m_shadow; enter(0); end
                    else m_ph = -1;
                end else enter(m_ph + 1);
            end
        end
        m_str = (m_ph == 2) && !m_s1 && (m_holds >= 2);
        m_s2 = m_s1; m_s1 = scl; m_shadow = nsh;
    endtask

    function automatic logic [9:0] m_vec();
        logic [1:0] p;
        p = (m_ph < 0) ? 2'd0 : 2'(m_ph);
        return {(m_ph == 0 || m_ph == 1), p, (m_ph != -1),
                m_tick[0], m_tick[1], m_tick[2], m_tick[3], m_str, m_to};
    endfunction

    always @(negedge clk) begin
        if (rst) model_reset();
        check($sformatf("cycle%0d", cyc), dut_vec(), m_vec());
        if (!rst) model_step(en, dl, int'(dv), scl_in);
    end

    function automatic bit sig(input int sel);
        case (sel)
            0: return ft;
            1: return dt;
            2: return rt;
            3: return st;
            4: return sto;
            default: return !busy;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input int maxc, input string name, output int t);
        int n;
        n = 0;
        t = -1;
        while (t < 0) begin
            @(negedge clk);
            n++;
            if (sig(sel)) t = cyc;
            else if (n >= maxc) begin
                n_checks++; n_err++;
                $display("FAIL %s: no event within %0d cycles", name, maxc);
                t = cyc;
            end
        end
    endtask

    task automatic load(input int v);
        @(posedge clk); #1; dl = 1; dv = 16'(v);
        @(posedge clk); #1; dl = 0;
    endtask

    task automatic go_idle();
        int t;
        @(posedge clk); #1; en = 0;
        wait_sig(5, 2000, "go_idle", t);
    endtask

    initial begin
        int t0, t1, t2;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", dut_vec(), 10'd0);
        rst = 0;

        // Default divisor after reset: 4*125+2.
        @(posedge clk); #1; en = 1;
        wait_sig(0, 10, "default_first_fall", t0);
        wait_sig(0, 600, "default_period", t1);
        check("default_period", t1 - t0, 502);

        // Ideal bus, Q=4.
        go_idle();
        load(4);
        en = 1;
        wait_sig(0, 10, "t1_fall0", t0);
        wait_sig(1, 40, "t1_low_a", t1);  check("t1_low_a", t1 - t0, 4);
        wait_sig(2, 40, "t1_low_b", t2);  check("t1_low_b", t2 - t1, 4);
        wait_sig(3, 40, "t1_high_a", t1); check("t1_high_a", t1 - t2, 6);
        wait_sig(0, 40, "t1_high_b", t2); check("t1_high_b", t2 - t1, 4);
        wait_sig(0, 40, "t1_period", t1); check("t1_period", t1 - t2, 18);

        // Slave holds SCL low for 10 cycles after rise_tick.
        wait_sig(1, 40, "t2_data", t0);
        @(posedge clk); #1; hold_low = 1;
        wait_sig(2, 40, "t2_rise", t0);
        fork
            begin repeat (10) @(posedge clk); #1; hold_low = 0; end
            wait_sig(3, 60, "t2_sample", t1);
        join
        check("t2_high_a_len", t1 - t0, 16);

        // Stuck-low SCL hits the stretch timeout.
        wait_sig(1, 40, "t3_data", t0);
        @(posedge clk); #1; hold_low = 1; en = 0;
        wait_sig(2, 40, "t3_rise", t0);
        wait_sig(4, 60, "t3_timeout", t1);
        check("t3_timeout_delay", t1 - t0, SMAX);
        check("t3_idle_after", {busy, scl_oe}, 2'b00);
        @(posedge clk); #1; hold_low = 0;

        // Divisor change mid-bit.
        load(4);
        en = 1;
        wait_sig(0, 10, "t4_fall0", t0);
        wait_sig(1, 40, "t4_data", t1);
        load(8);
        wait_sig(0, 40, "t4_fall1", t1); check("t4_current_bit", t1 - t0, 18);
        wait_sig(0, 60, "t4_fall2", t2); check("t4_next_bit", t2 - t1, 34);

        // Zero divisor clamps to 2.
        go_idle();
        load(0);
        en = 1;
        wait_sig(0, 10, "t5_fall0", t0);
        wait_sig(0, 30, "t5_fall1", t1);
        check("t5_period", t1 - t0, 10);

        // enable dropped in LOW_A: bit completes then idles.
        go_idle();
        load(4);
        en = 1;
        wait_sig(0, 10, "t6_fall", t0);
        @(posedge clk); #1; en = 0;
        wait_sig(3, 40, "t6_sample", t1); check("t6_bit_completes", t1 - t0, 14);
        wait_sig(5, 40, "t6_idle", t2);   check("t6_idle_after_high_b", t2 - t1, 4);

        // Async reset mid-HIGH_B clears outputs without a clock edge.
        @(posedge clk); #1; en = 1;
        wait_sig(3, 40, "t6_sample2", t0);
        @(posedge clk); #1;
        #2 rst = 1;
        #1 check("t6_async_reset", dut_vec(), 10'd0);
        @(posedge clk); #1; rst = 0; en = 0;

        // Randomised run.
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            en = ($urandom_range(0, 15) != 0);
            dl = ($urandom_range(0, 30) == 0);
            dv = 16'($urandom_range(0, 7));
            if (hold_low) hold_low = ($urandom_range(0, 7) != 0);
            else          hold_low = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                #2 rst = 1;
                @(posedge clk); #1; rst = 0;
            end
        end

        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
